// File: rtl/stat_counter_ctrl_if.sv
// Host-side command and readout port of the instruction-statistics counter controller.
// The slave modport is the controller view; the master modport is the debug/host view.
interface stat_counter_ctrl_if #(
  parameter int CW = 32
);
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          dump_req;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] rd_data;
  logic [1:0]    rd_idx;
  logic          rd_last;

  modport master (
    output cmd_valid, cmd_op, dump_req, rd_ready,
    input  cmd_ready, rd_valid, rd_data, rd_idx, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_op, dump_req, rd_ready,
    output cmd_ready, rd_valid, rd_data, rd_idx, rd_last
  );
endinterface

// File: rtl/stat_counter_ctrl.sv
// Instruction-statistics counter controller: run/stop/clear gating with an
// optional auto-stop window, plus snapshot-and-stream readout of the four counts.
module stat_counter_ctrl #(
  parameter int WINDOW = 0,
  parameter int CW     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  stat_counter_ctrl_if.slave   bus,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  input  logic [CW-1:0]        r_count_in,
  input  logic [CW-1:0]        i_count_in,
  input  logic [CW-1:0]        j_count_in,
  input  logic [CW-1:0]        total_count_in,
  output logic                 snap_mismatch,
  output logic                 window_done,
  output logic                 busy
);

  localparam logic [1:0]  OP_START = 2'b01;
  localparam logic [1:0]  OP_STOP  = 2'b10;
  localparam logic [1:0]  OP_CLEAR = 2'b11;
  localparam logic [31:0] WIN_LAST = 32'(WINDOW - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CLEAR, S_SNAP, S_DUMP} state_t;

  state_t        state, nxt, ret_state;
  logic [31:0]   win_cnt, win_cnt_d;
  logic [CW-1:0] snap_q [4];
  logic          cmd_acc, start_cmd, stop_cmd, clr_cmd, win_hit, rd_fire;
  logic          cnt_en_d, cnt_clr_d, busy_d, window_done_d;

  // Type counts that do not add up to the total (modulo counter width) flag a bank fault.
  function automatic logic sum_mismatch(input logic [CW-1:0] r, input logic [CW-1:0] i,
                                        input logic [CW-1:0] j, input logic [CW-1:0] t);
    logic [CW-1:0] s;
    s = r + i + j;
    return s != t;
  endfunction

  assign bus.cmd_ready = (state == S_IDLE) || (state == S_RUN);
  assign bus.rd_last   = bus.rd_valid && (bus.rd_idx == 2'd3);

  assign cmd_acc   = bus.cmd_valid && bus.cmd_ready;
  assign start_cmd = cmd_acc && (bus.cmd_op == OP_START);
  assign stop_cmd  = cmd_acc && (bus.cmd_op == OP_STOP);
  assign clr_cmd   = cmd_acc && (bus.cmd_op == OP_CLEAR);
  assign win_hit   = (WINDOW != 0) && (state == S_RUN) && (win_cnt == WIN_LAST);
  assign rd_fire   = bus.rd_valid && bus.rd_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next state: commands beat window expiry, window expiry beats a dump request.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (start_cmd)                      nxt = S_RUN;
        else if (clr_cmd)                   nxt = S_CLEAR;
        else if (!cmd_acc && bus.dump_req)  nxt = S_SNAP;
      end
      S_RUN: begin
        if (stop_cmd)                       nxt = S_IDLE;
        else if (clr_cmd)                   nxt = S_CLEAR;
        else if (win_hit)                   nxt = S_IDLE;
        else if (!cmd_acc && bus.dump_req)  nxt = S_SNAP;
      end
      S_CLEAR: nxt = ret_state;
      S_SNAP:  nxt = S_DUMP;
      S_DUMP: begin
        if (rd_fire && (bus.rd_idx == 2'd3)) nxt = ret_state;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs and the window counter.
  always_comb begin
    cnt_en_d      = (nxt == S_RUN);
    cnt_clr_d     = (nxt == S_CLEAR);
    busy_d        = (nxt == S_CLEAR) || (nxt == S_SNAP) || (nxt == S_DUMP);
    window_done_d = win_hit && !stop_cmd && !clr_cmd;
    win_cnt_d     = win_cnt;
    if (((state == S_IDLE) && start_cmd) || clr_cmd)
      win_cnt_d = '0;
    else if ((state == S_RUN) && (WINDOW != 0))
      win_cnt_d = win_cnt + 32'd1;
  end

  // Output, window, snapshot and readout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_en        <= 1'b0;
      cnt_clr       <= 1'b0;
      busy          <= 1'b0;
      window_done   <= 1'b0;
      win_cnt       <= '0;
      ret_state     <= S_IDLE;
      snap_mismatch <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_idx    <= 2'd0;
      for (int k = 0; k < 4; k++) snap_q[k] <= '0;
    end else begin
      cnt_en      <= cnt_en_d;
      cnt_clr     <= cnt_clr_d;
      busy        <= busy_d;
      window_done <= window_done_d;
      win_cnt     <= win_cnt_d;
      // Remember where to come back to after a clear pulse or a readout.
      if ((state == S_IDLE) || (state == S_RUN)) ret_state <= state;
      if (state == S_SNAP) begin
        snap_q[0]     <= total_count_in;
        snap_q[1]     <= r_count_in;
        snap_q[2]     <= i_count_in;
        snap_q[3]     <= j_count_in;
        snap_mismatch <= sum_mismatch(r_count_in, i_count_in, j_count_in, total_count_in);
        bus.rd_valid  <= 1'b1;
        bus.rd_idx    <= 2'd0;
        bus.rd_data   <= total_count_in;
      end else if ((state == S_DUMP) && rd_fire) begin
        if (bus.rd_idx == 2'd3) begin
          bus.rd_valid <= 1'b0;
          bus.rd_idx   <= 2'd0;
        end else begin
          bus.rd_idx  <= bus.rd_idx + 2'd1;
          bus.rd_data <= snap_q[bus.rd_idx + 2'd1];
        end
      end
    end
  end

endmodule

// File: tb/tb_stat_counter_ctrl.sv
// Directed bench for stat_counter_ctrl: three instances with WINDOW = 0, 5 and 20
// share clock, reset, command opcode and count inputs; each has its own strobes.
module tb_stat_counter_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_valid, dump_req, rd_ready;
  logic [31:0] r_in, i_in, j_in, t_in;

  logic [2:0]  cmd_ready, cnt_en, cnt_clr, rd_valid, rd_last;
  logic [2:0]  snap_mismatch, window_done, busy;
  logic [31:0] rd_data [3];
  logic [1:0]  rd_idx  [3];

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 5 : 20;
    stat_counter_ctrl_if #(.CW(32)) bus ();
    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_op    = cmd_op;
    assign bus.dump_req  = dump_req[g];
    assign bus.rd_ready  = rd_ready[g];
    assign cmd_ready[g]  = bus.cmd_ready;
    assign rd_valid[g]   = bus.rd_valid;
    assign rd_data[g]    = bus.rd_data;
    assign rd_idx[g]     = bus.rd_idx;
    assign rd_last[g]    = bus.rd_last;
    stat_counter_ctrl #(.WINDOW(W), .CW(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .cnt_en         (cnt_en[g]),
      .cnt_clr        (cnt_clr[g]),
      .r_count_in     (r_in),
      .i_count_in     (i_in),
      .j_count_in     (j_in),
      .total_count_in (t_in),
      .snap_mismatch  (snap_mismatch[g]),
      .window_done    (window_done[g]),
      .busy           (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int en_cnt, wd_cnt, wd_at;
    logic [31:0] w4 [4];
    logic [31:0] w5 [4];
    w4[0] = 100; w4[1] = 40; w4[2] = 50; w4[3] = 10;
    w5[0] = 7;   w5[1] = 1;  w5[2] = 1;  w5[3] = 1;

    reset = 1'b1; cmd_op = NOP; cmd_valid = '0; dump_req = '0; rd_ready = '0;
    r_in = 0; i_in = 0; j_in = 0; t_in = 0;
    tick; tick;
    chk("rst_cnt_en", cnt_en, 3'b000);
    chk("rst_cnt_clr", cnt_clr, 3'b000);
    chk("rst_cmd_ready", cmd_ready, 3'b111);
    chk("rst_busy", busy, 3'b000);
    chk("rst_rd_valid", rd_valid, 3'b000);
    chk("rst_rd_data", rd_data[0], 0);
    chk("rst_rd_idx", rd_idx[0], 0);
    chk("rst_rd_last", rd_last, 3'b000);
    chk("rst_mismatch", snap_mismatch, 3'b000);
    chk("rst_window_done", window_done, 3'b000);
    reset = 1'b0;
    tick;

    // Start/stop with an unlimited window.
    cmd_op = START; cmd_valid[0] = 1'b1;
    tick;
    cmd_valid[0] = 1'b0;
    en_cnt = 0; wd_cnt = 0;
    if (cnt_en[0]) en_cnt++;
    for (int n = 0; n < 9; n++) begin
      tick;
      if (cnt_en[0]) en_cnt++;
      if (window_done[0]) wd_cnt++;
    end
    chk("run_en_cycles", en_cnt, 10);
    cmd_op = STOP; cmd_valid[0] = 1'b1;
    tick;
    cmd_valid[0] = 1'b0;
    chk("stop_cnt_en", cnt_en[0], 0);
    chk("stop_cmd_ready", cmd_ready[0], 1);
    chk("nowin_no_done", wd_cnt, 0);

    // Auto-stop after a five-cycle window.
    cmd_op = START; cmd_valid[1] = 1'b1;
    tick;
    cmd_valid[1] = 1'b0;
    en_cnt = 0; wd_cnt = 0; wd_at = 0;
    for (int n = 1; n <= 12; n++) begin
      if (cnt_en[1]) en_cnt++;
      if (window_done[1]) begin
        wd_cnt++;
        wd_at = n;
        chk("win5_en_at_done", cnt_en[1], 0);
      end
      tick;
    end
    chk("win5_en_cycles", en_cnt, 5);
    chk("win5_done_pulses", wd_cnt, 1);
    chk("win5_done_sample", wd_at, 6);
    chk("win5_cmd_ready", cmd_ready[1], 1);
    chk("win5_idle_busy", busy[1], 0);

    // Clear while running, then clear while idle.
    cmd_op = START; cmd_valid[0] = 1'b1;
    tick;
    cmd_valid[0] = 1'b0;
    tick;
    cmd_op = CLEAR; cmd_valid[0] = 1'b1;
    tick;
    cmd_valid[0] = 1'b0;
    chk("clr_run_pulse", cnt_clr[0], 1);
    chk("clr_run_en", cnt_en[0], 0);
    chk("clr_run_ready", cmd_ready[0], 0);
    chk("clr_run_busy", busy[0], 1);
    tick;
    chk("clr_run_pulse_end", cnt_clr[0], 0);
    chk("clr_run_resume", cnt_en[0], 1);
    cmd_op = STOP; cmd_valid[0] = 1'b1;
    tick;
    cmd_op = CLEAR;
    tick;
    cmd_valid[0] = 1'b0;
    chk("clr_idle_pulse", cnt_clr[0], 1);
    chk("clr_idle_en", cnt_en[0], 0);
    tick;
    chk("clr_idle_pulse_end", cnt_clr[0], 0);
    tick;
    chk("clr_idle_stays", cnt_en[0], 0);
    chk("clr_idle_ready", cmd_ready[0], 1);

    // Dump from idle with a stalling consumer.
    t_in = 100; r_in = 40; i_in = 50; j_in = 10;
    dump_req[0] = 1'b1;
    tick;
    dump_req[0] = 1'b0;
    chk("snap_busy", busy[0], 1);
    chk("snap_no_valid", rd_valid[0], 0);
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("dump_valid", rd_valid[0], 1);
      chk("dump_data", rd_data[0], w4[k]);
      chk("dump_idx", rd_idx[0], k);
      chk("dump_last", rd_last[0], (k == 3) ? 1 : 0);
      if (k == 0) begin t_in = 999; r_in = 1; i_in = 2; j_in = 3; end
      tick;
      chk("dump_hold_data", rd_data[0], w4[k]);
      chk("dump_hold_valid", rd_valid[0], 1);
      rd_ready[0] = 1'b1;
      tick;
      rd_ready[0] = 1'b0;
    end
    chk("dump_end_valid", rd_valid[0], 0);
    chk("dump_end_busy", busy[0], 0);
    chk("dump_end_en", cnt_en[0], 0);
    chk("dump_end_ready", cmd_ready[0], 1);
    chk("dump_mismatch0", snap_mismatch[0], 0);

    // Dump from run mid-window; counting resumes afterwards.
    t_in = 7; r_in = 1; i_in = 1; j_in = 1;
    cmd_op = START; cmd_valid[2] = 1'b1;
    tick;
    cmd_valid[2] = 1'b0;
    en_cnt = 0;
    if (cnt_en[2]) en_cnt++;
    for (int n = 0; n < 7; n++) begin
      tick;
      if (cnt_en[2]) en_cnt++;
    end
    dump_req[2] = 1'b1;
    tick;
    dump_req[2] = 1'b0;
    chk("run_dump_pre_cycles", en_cnt, 8);
    chk("run_snap_en", cnt_en[2], 0);
    chk("run_snap_busy", busy[2], 1);
    tick;
    chk("run_mismatch", snap_mismatch[2], 1);
    rd_ready[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("run_dump_data", rd_data[2], w5[k]);
      chk("run_dump_idx", rd_idx[2], k);
      chk("run_dump_en", cnt_en[2], 0);
      tick;
    end
    rd_ready[2] = 1'b0;
    chk("run_dump_end_valid", rd_valid[2], 0);
    chk("run_resume_en", cnt_en[2], 1);
    en_cnt = 0; wd_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      if (cnt_en[2]) en_cnt++;
      if (window_done[2]) wd_cnt++;
      tick;
    end
    chk("run_rest_cycles", en_cnt, 12);
    chk("run_rest_done", wd_cnt, 1);
    chk("run_mismatch_hold", snap_mismatch[2], 1);

    // Command has priority over a same-cycle dump request.
    cmd_op = START; cmd_valid[0] = 1'b1; dump_req[0] = 1'b1;
    tick;
    cmd_valid[0] = 1'b0; dump_req[0] = 1'b0;
    chk("prio_en", cnt_en[0], 1);
    chk("prio_busy", busy[0], 0);
    tick;
    chk("prio_no_snap", busy[0], 0);
    chk("prio_no_valid", rd_valid[0], 0);
    cmd_op = STOP; cmd_valid[0] = 1'b1;
    tick;
    cmd_valid[0] = 1'b0;
    chk("prio_stop", cnt_en[0], 0);

    // Asynchronous reset during a stalled readout.
    cmd_op = START; cmd_valid[2] = 1'b1; dump_req[0] = 1'b1;
    tick;
    cmd_valid[2] = 1'b0; dump_req[0] = 1'b0;
    tick;
    chk("arst_pre_valid", rd_valid[0], 1);
    tick;
    chk("arst_stall_valid", rd_valid[0], 1);
    chk("arst_pre_run", cnt_en[2], 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", rd_valid[0], 0);
    chk("arst_en", cnt_en[2], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_ready", cmd_ready[0], 1);
    chk("arst_data", rd_data[0], 0);
    chk("arst_mismatch", snap_mismatch[2], 0);
    #2 reset = 1'b0;
    tick;
    chk("arst_after_valid", rd_valid[0], 0);
    chk("arst_after_en", cnt_en[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
